// File: rtl/nn_inference_sequencer.sv
// Control sequencer for one 784-56-10 inference: issues constant-memory fetches,
// hands rows to the MAC/activation datapaths and watches every wait for a stall.
module nn_inference_sequencer #(
    parameter int N_IN    = 784,
    parameter int N_HID   = 56,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       b0_fetch,
    output logic       w0_fetch,
    output logic       b1_fetch,
    output logic       w1_fetch,
    output logic [9:0] pixel_no,
    output logic [5:0] l1_no,
    input  logic       b0_complete,
    input  logic       w0_complete,
    input  logic       b1_complete,
    input  logic       w1_complete,
    output logic       load_bias0,
    output logic       load_bias1,
    output logic       mac0_start,
    output logic       mac1_start,
    input  logic       mac0_done,
    input  logic       mac1_done,
    output logic       act_start,
    input  logic       act_done,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_B0_FETCH, S_B0_LOAD, S_W0_FETCH, S_W0_MAC, S_ACT,
        S_B1_FETCH, S_B1_LOAD, S_W1_FETCH, S_W1_MAC, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [9:0]        p, p_nxt;
    logic [5:0]        h, h_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic              error_nxt;
    logic              first_cycle;

    function automatic logic is_wait(input state_t s);
        return (s == S_B0_FETCH) || (s == S_W0_FETCH) || (s == S_W0_MAC) || (s == S_ACT) ||
               (s == S_B1_FETCH) || (s == S_W1_FETCH) || (s == S_W1_MAC);
    endfunction

    // The watchdog clears on every entry, so a zero count marks the start-pulse
    // cycle in which a same-cycle done must be ignored.
    assign first_cycle = (wd == '0);

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        h_nxt     = h;
        wd_nxt    = '0;
        error_nxt = error;
        case (state)
            S_IDLE, S_ERR: if (start) begin
                state_nxt = S_B0_FETCH;
                error_nxt = 1'b0;
                p_nxt     = '0;
                h_nxt     = '0;
            end
            S_B0_FETCH: if (b0_complete) state_nxt = S_B0_LOAD;
            S_B0_LOAD:  state_nxt = S_W0_FETCH;
            S_W0_FETCH: if (w0_complete) state_nxt = S_W0_MAC;
            S_W0_MAC: if (!first_cycle && mac0_done) begin
                if (p == 10'(N_IN - 1)) begin
                    state_nxt = S_ACT;
                end else begin
                    state_nxt = S_W0_FETCH;
                    p_nxt     = p + 10'd1;
                end
            end
            S_ACT:      if (!first_cycle && act_done) state_nxt = S_B1_FETCH;
            S_B1_FETCH: if (b1_complete) state_nxt = S_B1_LOAD;
            S_B1_LOAD:  state_nxt = S_W1_FETCH;
            S_W1_FETCH: if (w1_complete) state_nxt = S_W1_MAC;
            S_W1_MAC: if (!first_cycle && mac1_done) begin
                if (h == 6'(N_HID - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_W1_FETCH;
                    h_nxt     = h + 6'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // A completion arriving on the last allowed cycle still wins over the timeout.
        if (is_wait(state) && state_nxt == state) begin
            if (wd == WD_W'(TIMEOUT - 1)) begin
                state_nxt = S_ERR;
                error_nxt = 1'b1;
            end else begin
                wd_nxt = wd + 1'b1;
            end
        end

        if (abort) begin
            state_nxt = S_IDLE;
            p_nxt     = '0;
            h_nxt     = '0;
            wd_nxt    = '0;
            error_nxt = error;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            p          <= '0;
            h          <= '0;
            wd         <= '0;
            error      <= 1'b0;
            b0_fetch   <= 1'b0;
            w0_fetch   <= 1'b0;
            b1_fetch   <= 1'b0;
            w1_fetch   <= 1'b0;
            load_bias0 <= 1'b0;
            load_bias1 <= 1'b0;
            mac0_start <= 1'b0;
            mac1_start <= 1'b0;
            act_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            p          <= p_nxt;
            h          <= h_nxt;
            wd         <= wd_nxt;
            error      <= error_nxt;
            b0_fetch   <= (state_nxt == S_B0_FETCH);
            w0_fetch   <= (state_nxt == S_W0_FETCH);
            b1_fetch   <= (state_nxt == S_B1_FETCH);
            w1_fetch   <= (state_nxt == S_W1_FETCH);
            load_bias0 <= (state_nxt == S_B0_LOAD);
            load_bias1 <= (state_nxt == S_B1_LOAD);
            mac0_start <= (state_nxt == S_W0_MAC) && (state != S_W0_MAC);
            mac1_start <= (state_nxt == S_W1_MAC) && (state != S_W1_MAC);
            act_start  <= (state_nxt == S_ACT) && (state != S_ACT);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (state_nxt != S_ERR);
            done       <= (state_nxt == S_DONE);
        end
    end

    assign pixel_no = p;
    assign l1_no    = h;
endmodule
